// File: rtl/soc_apb_timer_pkg.sv
// Shared types and constants for the APB timer control stage.
package soc_apb_timer_pkg;

  // Default prescaler divider width.
  localparam int unsigned PRESC_W_DEFAULT = 8;

  // Values of cfg_oneshot_i.
  localparam logic MODE_CONTINUOUS = 1'b0;
  localparam logic MODE_ONESHOT    = 1'b1;

  // Run/one-shot controller states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/soc_apb_timer_prescaler.sv
// Programmable prescaler: counts 0..presc_val_i while enabled and
// flags a tick on the terminal count. A value change below the current
// count makes the counter run on and wrap through 2^PRESC_W.
module soc_apb_timer_prescaler
  import soc_apb_timer_pkg::*;
#(
  parameter int unsigned PRESC_W = PRESC_W_DEFAULT
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clr_i,
  input  logic               en_i,
  input  logic [PRESC_W-1:0] presc_val_i,
  output logic               tick_o
);

  logic [PRESC_W-1:0] cnt_q, cnt_d;
  logic               wrap;

  assign wrap   = (cnt_q == presc_val_i);
  assign tick_o = en_i & wrap;

  // Next count: held at 0 when cleared or disabled, else count and wrap.
  always_comb begin
    cnt_d = cnt_q + PRESC_W'(1);
    if (clr_i || !en_i) begin
      cnt_d = '0;
    end else if (wrap) begin
      cnt_d = '0;
    end
  end

  // Prescaler count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/soc_apb_timer_ctrl.sv
// Timer control stage: generates reset/enable strobes for the timer
// counter from a prescaler and a run/one-shot FSM, and turns the
// counter's compare flag into an event pulse and a sticky interrupt.
// Optional feature macro: SOC_APB_TIMER_PRESCALER_EN (when undefined the
// prescaler is absent and the counter ticks every cycle in RUN).
//
// Control inputs start_i, stop_i, clr_i and irq_ack_i are single-cycle
// pulses sampled on every rising clock edge; there is no back-pressure.
module soc_apb_timer_ctrl
  import soc_apb_timer_pkg::*;
#(
  parameter int unsigned PRESC_W = PRESC_W_DEFAULT
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic               stop_i,
  input  logic               clr_i,
  input  logic               cfg_oneshot_i,
  input  logic [PRESC_W-1:0] cfg_presc_val_i,
  input  logic               cfg_irq_en_i,
  input  logic               irq_ack_i,
  input  logic               target_reached_i,
  output logic               reset_count_o,
  output logic               enable_count_o,
  output logic               event_o,
  output logic               irq_o,
  output logic               busy_o,
  output logic [1:0]         dbg_state_o
);

  state_e state_q, state_d;
  logic   run;
  logic   tick;
  logic   start_eff;
  logic   evt;
  logic   chg_q, chg_d;
  logic   event_q, event_d;
  logic   irq_q, irq_d;

  assign run       = (state_q == ST_RUN);
  // Stop dominates a simultaneous start, so no restart strobe is issued.
  assign start_eff = start_i & ~stop_i;

`ifdef SOC_APB_TIMER_PRESCALER_EN
  soc_apb_timer_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_prescaler (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clr_i       (start_i | stop_i),
    .en_i        (run),
    .presc_val_i (cfg_presc_val_i),
    .tick_o      (tick)
  );
`else
  // Without a prescaler the counter advances every cycle while running.
  logic unused_presc_val;
  assign unused_presc_val = ^cfg_presc_val_i;
  assign tick             = run;
`endif

  // Counter strobes. In continuous mode a tick on compare reloads 0;
  // in one-shot mode the count parks on compare.
  assign reset_count_o  = clr_i | start_eff |
                          (run & (cfg_oneshot_i == MODE_CONTINUOUS) & tick & target_reached_i);
  assign enable_count_o = run & tick & ~target_reached_i & ~reset_count_o;

  // An event is a counter update that lands on the compare value.
  assign evt = target_reached_i & chg_q;

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (stop_i) begin
          state_d = ST_IDLE;
        end else if (start_i) begin
          state_d = ST_RUN;
        end else if (evt && (cfg_oneshot_i == MODE_ONESHOT)) begin
          state_d = ST_DONE;
        end
      end
      default: begin
        if (start_eff) begin
          state_d = ST_RUN;
        end
      end
    endcase
  end

  // Update-tracking, event and interrupt next values; irq set beats ack.
  always_comb begin
    chg_d   = reset_count_o | enable_count_o;
    event_d = evt;
    irq_d   = irq_q;
    if (evt && cfg_irq_en_i) begin
      irq_d = 1'b1;
    end else if (irq_ack_i) begin
      irq_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      chg_q   <= 1'b0;
      event_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      chg_q   <= chg_d;
      event_q <= event_d;
      irq_q   <= irq_d;
    end
  end

  assign event_o     = event_q;
  assign irq_o       = irq_q;
  assign busy_o      = run;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_soc_apb_timer_ctrl.sv
// Bench for soc_apb_timer_ctrl: a simple timer counter closes the loop,
// and an arithmetic schedule model predicts every strobe and event.
module tb_soc_apb_timer_ctrl;

  localparam int W = 16;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       start_i = 1'b0;
  logic       stop_i = 1'b0;
  logic       clr_i = 1'b0;
  logic       cfg_oneshot_i = 1'b0;
  logic [7:0] cfg_presc_val_i = 8'd0;
  logic       cfg_irq_en_i = 1'b0;
  logic       irq_ack_i = 1'b0;
  logic       target_reached_i;
  logic       reset_count_o;
  logic       enable_count_o;
  logic       event_o;
  logic       irq_o;
  logic       busy_o;
  logic [1:0] dbg_state_o;

  logic [7:0] tcnt = 8'd0;
  logic [7:0] cmp = 8'd0;

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];

  soc_apb_timer_ctrl #(.PRESC_W(8)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .start_i          (start_i),
    .stop_i           (stop_i),
    .clr_i            (clr_i),
    .cfg_oneshot_i    (cfg_oneshot_i),
    .cfg_presc_val_i  (cfg_presc_val_i),
    .cfg_irq_en_i     (cfg_irq_en_i),
    .irq_ack_i        (irq_ack_i),
    .target_reached_i (target_reached_i),
    .reset_count_o    (reset_count_o),
    .enable_count_o   (enable_count_o),
    .event_o          (event_o),
    .irq_o            (irq_o),
    .busy_o           (busy_o),
    .dbg_state_o      (dbg_state_o)
  );

  // Clock.
  always #5 clk_i = ~clk_i;

  // Timer counter driven by the strobes; compare flag follows the count.
  always_ff @(posedge clk_i) begin
    if (reset_count_o) tcnt <= 8'd0;
    else if (enable_count_o) tcnt <= tcnt + 8'd1;
  end
  assign target_reached_i = (tcnt == cmp);

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic int eff_presc(input int p);
`ifdef SOC_APB_TIMER_PRESCALER_EN
    return p;
`else
    return 0;
`endif
  endfunction

  // Expected strobes k cycles after start (k=0 is the start cycle).
  function automatic void model_strobes(input int k, input int c, input int p, input bit os,
                                        output bit e_rst, output bit e_en);
    int lat, j, pos;
    lat   = c * (p + 1) + 2;
    e_rst = 1'b0;
    e_en  = 1'b0;
    if (k == 0) begin
      e_rst = 1'b1;
    end else if ((k % (p + 1)) == 0 && (!os || k < lat)) begin
      j = k / (p + 1);
      if (os) begin
        e_en = (j <= c);
      end else begin
        pos   = (j - 1) % (c + 1);
        e_en  = (pos < c);
        e_rst = (pos == c);
      end
    end
  endfunction

  // Idle the timer, clear irq, load config, start and check n cycles.
  task automatic run_case(input int c, input int p_cfg, input bit os, input bit ien, input int ncyc);
    int p, lat, per;
    bit e_rst, e_en, e_evt, e_busy, e_irq;
    string tg;
    stop_i = 1'b1; step(); stop_i = 1'b0;
    repeat (3) step();
    irq_ack_i = 1'b1; step(); irq_ack_i = 1'b0;
    cmp = 8'(c);
    cfg_presc_val_i = 8'(p_cfg);
    cfg_oneshot_i = os;
    cfg_irq_en_i = ien;
    step();
    p   = eff_presc(p_cfg);
    lat = c * (p + 1) + 2;
    per = (c + 1) * (p + 1);
    exp_q.delete();
    if (os) begin
      exp_q.push_back(W'(lat));
    end else begin
      for (int t = lat; t < ncyc; t += per) exp_q.push_back(W'(t));
    end
    for (int k = 0; k < ncyc; k++) begin
      start_i = (k == 0);
      @(negedge clk_i);
      model_strobes(k, c, p, os, e_rst, e_en);
      e_evt = (exp_q.size() > 0) && (exp_q[0] == W'(k));
      if (e_evt) void'(exp_q.pop_front());
      e_busy = os ? (k >= 1 && k < lat) : (k >= 1);
      e_irq  = ien && (k >= lat);
      tg = $sformatf("c%0d p%0d os%0d k%0d", c, p_cfg, os, k);
      check({tg, " reset_count"}, reset_count_o, e_rst);
      check({tg, " enable_count"}, enable_count_o, e_en);
      check({tg, " event"}, event_o, e_evt);
      check({tg, " busy"}, busy_o, e_busy);
      check({tg, " irq"}, irq_o, e_irq);
      step();
    end
    start_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int c, p, l;
    bit os, ien;
    // Reset state.
    repeat (3) @(posedge clk_i);
    #1; rst_ni = 1'b1;
    @(negedge clk_i);
    check("rst reset_count", reset_count_o, 1'b0);
    check("rst enable_count", enable_count_o, 1'b0);
    check("rst event", event_o, 1'b0);
    check("rst irq", irq_o, 1'b0);
    check("rst busy", busy_o, 1'b0);
    step();

    // Directed schedules.
    run_case(3, 0, 1'b0, 1'b1, 16);
    run_case(1, 2, 1'b0, 1'b1, 20);
    run_case(5, 0, 1'b1, 1'b1, 12);
    run_case(5, 0, 1'b1, 1'b1, 12);
    run_case(2, 7, 1'b0, 1'b0, 30);
    run_case(0, 0, 1'b0, 1'b1, 8);

    // Ack during a continuous compare-0 event stream: set wins.
    irq_ack_i = 1'b1; step(); irq_ack_i = 1'b0;
    @(negedge clk_i);
    check("ack with event irq", irq_o, 1'b1);
    step();
    stop_i = 1'b1; step(); stop_i = 1'b0;
    repeat (3) step();
    irq_ack_i = 1'b1; step(); irq_ack_i = 1'b0;
    @(negedge clk_i);
    check("ack idle irq", irq_o, 1'b0);
    step();

    // Start and stop together while running.
    cmp = 8'd3; cfg_oneshot_i = 1'b0; cfg_presc_val_i = 8'd0;
    start_i = 1'b1; step(); start_i = 1'b0;
    repeat (2) step();
    start_i = 1'b1; stop_i = 1'b1;
    @(negedge clk_i);
    check("start+stop reset_count", reset_count_o, 1'b0);
    check("start+stop busy same cycle", busy_o, 1'b1);
    step();
    start_i = 1'b0; stop_i = 1'b0;
    @(negedge clk_i);
    check("start+stop busy after", busy_o, 1'b0);
    check("start+stop enable after", enable_count_o, 1'b0);
    step();

    // Clear while idle.
    clr_i = 1'b1;
    @(negedge clk_i);
    check("clr reset_count", reset_count_o, 1'b1);
    check("clr busy", busy_o, 1'b0);
    step();
    clr_i = 1'b0;
    @(negedge clk_i);
    check("clr reset_count after", reset_count_o, 1'b0);
    check("clr busy after", busy_o, 1'b0);
    step();

    // Randomized schedules.
    for (int n = 0; n < 10; n++) begin
      c   = int'($urandom_range(0, 6));
      p   = int'($urandom_range(0, 3));
      os  = 1'($urandom_range(0, 1));
      ien = 1'($urandom_range(0, 1));
      l   = c * (eff_presc(p) + 1) + 2;
      run_case(c, p, os, ien, l + 2 * (c + 1) * (eff_presc(p) + 1) + 2);
    end

    // Asynchronous reset mid-run with irq pending.
    run_case(0, 0, 1'b0, 1'b1, 6);
    @(negedge clk_i);
    check("pre-reset irq", irq_o, 1'b1);
    check("pre-reset busy", busy_o, 1'b1);
    step();
    rst_ni = 1'b0;
    #1;
    check("async rst irq", irq_o, 1'b0);
    check("async rst busy", busy_o, 1'b0);
    check("async rst event", event_o, 1'b0);
    check("async rst reset_count", reset_count_o, 1'b0);
    check("async rst enable_count", enable_count_o, 1'b0);
    step();
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("post-reset busy", busy_o, 1'b0);
    check("post-reset irq", irq_o, 1'b0);
    check("post-reset event", event_o, 1'b0);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
